// File: rtl/cache_writeback_pkg.sv
// Shared constants for the dirty-victim write-back stage: AXI encodings,
// the write-back AXI ID and the FSM state encodings.
package cache_writeback_pkg;

  localparam logic [3:0] WB_AWID        = 4'h5;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef logic [2:0] wb_state_t;

  localparam wb_state_t S_IDLE = 3'd0;
  localparam wb_state_t S_SRD  = 3'd1;  // SRAM read issued
  localparam wb_state_t S_CAP  = 3'd2;  // SRAM data returns, captured
  localparam wb_state_t S_AW   = 3'd3;
  localparam wb_state_t S_W    = 3'd4;
  localparam wb_state_t S_B    = 3'd5;
  localparam wb_state_t S_DONE = 3'd6;

  // AXI awsize encoding for a beat of the given byte count
  function automatic logic [2:0] axi_size(input int bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/cache_writeback.sv
// cache_writeback: dirty-victim write-back stage.
// On a dirty miss it reads the victim line + tag from the victim way's SRAMs,
// writes the line to memory as one AXI-4 INCR burst, and pulses wb_rsp (with
// wb_err on a bad response) when the B response arrives.
// Ports:
//   clk / reset (async, active-low)
//   info_*            lookup result from the tag-compare stage
//   core_index        set index, stable until wb_rsp
//   wb_*_cen0/1, wb_sram_addr, data_rdata0/1, tag_rdata0/1   victim SRAM read
//   wb_aw*/wb_w*/wb_b*   AXI-4 write channels
//   wb_busy           FSM not idle
//   wb_rsp / wb_err   completion pulse / error qualifier
module cache_writeback
  import cache_writeback_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int BEATS    = 4,
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 2,
  parameter int ID_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    info_miss,
  input  logic                    info_rplc_dirty,
  input  logic                    info_rplc_way,
  input  logic                    info_rsp,
  input  logic [INDEX_W-1:0]      core_index,
  output logic                    wb_data_cen0,
  output logic                    wb_data_cen1,
  output logic                    wb_tag_cen0,
  output logic                    wb_tag_cen1,
  output logic [INDEX_W-1:0]      wb_sram_addr,
  input  logic [BEATS*DATA_W-1:0] data_rdata0,
  input  logic [BEATS*DATA_W-1:0] data_rdata1,
  input  logic [TAG_W-1:0]        tag_rdata0,
  input  logic [TAG_W-1:0]        tag_rdata1,
  output logic [ID_W-1:0]         wb_awid,
  output logic [ADDR_W-1:0]       wb_awaddr,
  output logic [7:0]              wb_awlen,
  output logic [2:0]              wb_awsize,
  output logic [1:0]              wb_awburst,
  output logic                    wb_awvalid,
  input  logic                    wb_awready,
  output logic [DATA_W-1:0]       wb_wdata,
  output logic [DATA_W/8-1:0]     wb_wstrb,
  output logic                    wb_wlast,
  output logic                    wb_wvalid,
  input  logic                    wb_wready,
  input  logic [ID_W-1:0]         wb_bid,
  input  logic [1:0]              wb_bresp,
  input  logic                    wb_bvalid,
  output logic                    wb_bready,
  output logic                    wb_busy,
  output logic                    wb_rsp,
  output logic                    wb_err
);

  localparam int LINE_W = BEATS * DATA_W;
  localparam int SIZE_W = $clog2(DATA_W / 8);

  wb_state_t           state_q, state_d;
  logic                way_q, way_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  logic start, last_beat;
  logic in_srd, in_aw, in_w;

  assign start     = info_miss & info_rplc_dirty & info_rsp;
  assign last_beat = (cnt_q == OFFSET_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    way_d   = way_q;
    line_d  = line_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        way_d   = info_rplc_way;
        state_d = S_SRD;
      end
      S_SRD: state_d = S_CAP;
      S_CAP: begin
        line_d  = way_q ? data_rdata1 : data_rdata0;
        tag_d   = way_q ? tag_rdata1  : tag_rdata0;
        state_d = S_AW;
      end
      S_AW: begin
        cnt_d = '0;
        if (wb_awready) state_d = S_W;
      end
      S_W: if (wb_wready) begin
        // Clear instead of incrementing past the last beat so the counter
        // never wraps inside a burst.
        if (last_beat) begin
          cnt_d   = '0;
          state_d = S_B;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_B: if (wb_bvalid) begin
        err_d   = (wb_bresp != AXI_RESP_OKAY) | (wb_bid != ID_W'(WB_AWID));
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      way_q   <= 1'b0;
      line_q  <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      line_q  <= line_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign in_srd = (state_q == S_SRD);
  assign in_aw  = (state_q == S_AW);
  assign in_w   = (state_q == S_W);

  // All outputs are decoded from state so an async reset forces them to 0.
  assign wb_data_cen0 = in_srd & ~way_q;
  assign wb_tag_cen0  = in_srd & ~way_q;
  assign wb_data_cen1 = in_srd &  way_q;
  assign wb_tag_cen1  = in_srd &  way_q;
  assign wb_sram_addr = in_srd ? core_index : '0;

  assign wb_awvalid = in_aw;
  assign wb_awid    = in_aw ? ID_W'(WB_AWID) : '0;
  assign wb_awaddr  = in_aw ? ADDR_W'({tag_q, core_index, {OFFSET_W{1'b0}}, {SIZE_W{1'b0}}}) : '0;
  assign wb_awlen   = in_aw ? 8'(BEATS - 1) : '0;
  assign wb_awsize  = in_aw ? axi_size(DATA_W / 8) : '0;
  assign wb_awburst = in_aw ? AXI_BURST_INCR : '0;

  assign wb_wvalid = in_w;
  assign wb_wdata  = in_w ? line_q[int'(cnt_q)*DATA_W +: DATA_W] : '0;
  assign wb_wstrb  = in_w ? '1 : '0;
  assign wb_wlast  = in_w & last_beat;

  assign wb_bready = (state_q == S_B);
  assign wb_busy   = (state_q != S_IDLE);
  assign wb_rsp    = (state_q == S_DONE);
  assign wb_err    = (state_q == S_DONE) & err_q;

endmodule

// File: tb/tb_cache_writeback.sv
// Self-checking bench for cache_writeback: directed cases plus randomized
// transactions, each checked against a transaction-level expectation
// (address from tag/index arithmetic, word k = line >> 32k, err from bresp/bid).
module tb_cache_writeback;

  logic         clk = 1'b0;
  logic         reset;
  logic         info_miss, info_rplc_dirty, info_rplc_way, info_rsp;
  logic [7:0]   core_index;
  logic         wb_data_cen0, wb_data_cen1, wb_tag_cen0, wb_tag_cen1;
  logic [7:0]   wb_sram_addr;
  logic [127:0] data_rdata0, data_rdata1;
  logic [19:0]  tag_rdata0, tag_rdata1;
  logic [3:0]   wb_awid;
  logic [31:0]  wb_awaddr;
  logic [7:0]   wb_awlen;
  logic [2:0]   wb_awsize;
  logic [1:0]   wb_awburst;
  logic         wb_awvalid, wb_awready;
  logic [31:0]  wb_wdata;
  logic [3:0]   wb_wstrb;
  logic         wb_wlast, wb_wvalid, wb_wready;
  logic [3:0]   wb_bid;
  logic [1:0]   wb_bresp;
  logic         wb_bvalid, wb_bready;
  logic         wb_busy, wb_rsp, wb_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [3:0] EXP_AWID = 4'h5;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cache_writeback dut (
    .clk(clk), .reset(reset),
    .info_miss(info_miss), .info_rplc_dirty(info_rplc_dirty),
    .info_rplc_way(info_rplc_way), .info_rsp(info_rsp),
    .core_index(core_index),
    .wb_data_cen0(wb_data_cen0), .wb_data_cen1(wb_data_cen1),
    .wb_tag_cen0(wb_tag_cen0), .wb_tag_cen1(wb_tag_cen1),
    .wb_sram_addr(wb_sram_addr),
    .data_rdata0(data_rdata0), .data_rdata1(data_rdata1),
    .tag_rdata0(tag_rdata0), .tag_rdata1(tag_rdata1),
    .wb_awid(wb_awid), .wb_awaddr(wb_awaddr), .wb_awlen(wb_awlen),
    .wb_awsize(wb_awsize), .wb_awburst(wb_awburst),
    .wb_awvalid(wb_awvalid), .wb_awready(wb_awready),
    .wb_wdata(wb_wdata), .wb_wstrb(wb_wstrb), .wb_wlast(wb_wlast),
    .wb_wvalid(wb_wvalid), .wb_wready(wb_wready),
    .wb_bid(wb_bid), .wb_bresp(wb_bresp), .wb_bvalid(wb_bvalid),
    .wb_bready(wb_bready),
    .wb_busy(wb_busy), .wb_rsp(wb_rsp), .wb_err(wb_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    data_rdata0 = {$urandom, $urandom, $urandom, $urandom};
    data_rdata1 = {$urandom, $urandom, $urandom, $urandom};
    tag_rdata0  = 20'($urandom);
    tag_rdata1  = 20'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  wb_busy, 0);
    chk({tag, "_cen"},   {wb_data_cen0, wb_data_cen1, wb_tag_cen0, wb_tag_cen1}, 0);
    chk({tag, "_axi"},   {wb_awvalid, wb_wvalid, wb_wlast, wb_bready}, 0);
    chk({tag, "_wdata"}, wb_wdata, 0);
    chk({tag, "_rsp"},   {wb_rsp, wb_err}, 0);
  endtask

  // One complete write-back. wmode: 0 wready always 1, 1 toggles 1,0,1,0..,
  // 2 random. early_b raises bvalid during W (must not be accepted).
  // poke pulses another start during AW (must be ignored).
  task automatic run_wb(input bit way, input logic [7:0] idx, input logic [19:0] tag,
                        input logic [127:0] line, input int aw_dly, input int wmode,
                        input int b_dly, input logic [1:0] bresp, input logic [3:0] bid,
                        input bit early_b, input bit poke, input bit expect_min);
    // Victim address: tag above index above 4 byte-address bits (2 word offset + 2 byte)
    logic [31:0] exp_addr;
    bit          exp_err;
    int          k, n, t0;
    exp_addr = (32'(tag) << 12) | (32'(idx) << 4);
    exp_err  = (bresp != 2'b00) || (bid != EXP_AWID);

    info_miss = 1; info_rplc_dirty = 1; info_rplc_way = way;
    core_index = idx; info_rsp = 1;
    @(posedge clk); #1;
    t0 = cyc;
    info_rsp = 0; info_miss = 0; info_rplc_dirty = 0;

    // SRD: only the victim way is selected
    chk("srd_dcen0", wb_data_cen0, !way);
    chk("srd_tcen0", wb_tag_cen0, !way);
    chk("srd_dcen1", wb_data_cen1, way);
    chk("srd_tcen1", wb_tag_cen1, way);
    chk("srd_addr", wb_sram_addr, idx);
    chk("srd_busy", wb_busy, 1);
    @(posedge clk); #1;
    // SRAM data valid one cycle after the select
    if (way) begin data_rdata1 = line; tag_rdata1 = tag; end
    else     begin data_rdata0 = line; tag_rdata0 = tag; end
    chk("cap_cen", {wb_data_cen0, wb_data_cen1, wb_tag_cen0, wb_tag_cen1}, 0);
    @(posedge clk); #1;
    scramble();

    n = 0;
    forever begin
      chk("aw_valid", wb_awvalid, 1);
      chk("aw_addr", wb_awaddr, exp_addr);
      chk("aw_len", wb_awlen, 3);
      chk("aw_size", wb_awsize, 2);
      chk("aw_burst", wb_awburst, 2'b01);
      chk("aw_id", wb_awid, EXP_AWID);
      chk("aw_wvalid", wb_wvalid, 0);
      if (poke && n == 0) begin
        info_miss = 1; info_rplc_dirty = 1; info_rplc_way = !way; info_rsp = 1;
      end
      wb_awready = (n >= aw_dly);
      @(posedge clk); #1;
      info_rsp = 0; info_miss = 0; info_rplc_dirty = 0;
      if (wb_awready) break;
      n++;
      if (n > 40) begin chk("aw_timeout", 1, 0); break; end
    end
    wb_awready = 0;
    if (early_b) begin wb_bvalid = 1; wb_bresp = bresp; wb_bid = bid; end

    k = 0; n = 0;
    while (k < 4) begin
      chk("w_valid", wb_wvalid, 1);
      chk("w_data", wb_wdata, line[k*32 +: 32]);
      chk("w_last", wb_wlast, k == 3);
      chk("w_strb", wb_wstrb, 4'hF);
      chk("w_bready", wb_bready, 0);
      chk("w_rsp", wb_rsp, 0);
      wb_wready = (wmode == 0) ? 1'b1 : (wmode == 1) ? 1'(n % 2 == 0) : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (wb_wready) k++;
      n++;
      if (n > 60) begin chk("w_timeout", 1, 0); break; end
    end
    wb_wready = 0;
    if (wmode == 1) chk("w_cycles", n, 7);

    n = 0;
    forever begin
      chk("b_bready", wb_bready, 1);
      chk("b_wvalid", wb_wvalid, 0);
      chk("b_rsp", wb_rsp, 0);
      wb_bvalid = early_b || (n >= b_dly);
      wb_bresp = bresp; wb_bid = bid;
      @(posedge clk); #1;
      if (wb_bvalid) break;
      n++;
      if (n > 40) begin chk("b_timeout", 1, 0); break; end
    end
    wb_bvalid = 0; wb_bresp = $urandom; wb_bid = $urandom;

    chk("done_rsp", wb_rsp, 1);
    chk("done_err", wb_err, exp_err);
    chk("done_bready", wb_bready, 0);
    if (expect_min) chk("latency", cyc - t0, 8);
    @(posedge clk); #1;
    chk("post_rsp", {wb_rsp, wb_err}, 0);
    chk("post_busy", wb_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0;
    info_miss = 0; info_rplc_dirty = 0; info_rplc_way = 0; info_rsp = 0;
    core_index = 0;
    wb_awready = 0; wb_wready = 0; wb_bvalid = 0; wb_bresp = 0; wb_bid = 0;
    scramble();
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    chk_all_zero("idle");

    // 1: way0, index 0x12, tag 0xABCDE, words 1..4, all readies immediate
    run_wb(0, 8'h12, 20'hABCDE, {32'd4, 32'd3, 32'd2, 32'd1}, 0, 0, 0, 2'b00, EXP_AWID, 0, 0, 1);
    // 2: way1 victim
    run_wb(1, 8'h7F, 20'h12345, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 2'b00, EXP_AWID, 0, 0, 1);
    // 3: awready after 3 cycles, wready toggling
    run_wb(0, 8'hA5, 20'h0F0F0, {$urandom, $urandom, $urandom, $urandom}, 3, 1, 1, 2'b00, EXP_AWID, 0, 0, 0);
    // 4: SLVERR, then a bid mismatch, then an early bvalid
    run_wb(1, 8'h01, 20'hFFFFF, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 2'b10, EXP_AWID, 0, 0, 1);
    run_wb(0, 8'hFF, 20'h00001, {$urandom, $urandom, $urandom, $urandom}, 1, 0, 0, 2'b00, 4'h2, 0, 0, 0);
    run_wb(0, 8'h00, 20'h80000, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 2'b00, EXP_AWID, 1, 0, 0);

    // 5: clean miss / hit with dirty victim / start while busy
    info_miss = 1; info_rplc_dirty = 0; info_rsp = 1;
    @(posedge clk); #1;
    info_miss = 0; info_rplc_dirty = 1;
    @(posedge clk); #1;
    info_rsp = 0; info_rplc_dirty = 0;
    for (int i = 0; i < 3; i++) begin
      chk_all_zero("clean");
      @(posedge clk); #1;
    end
    run_wb(1, 8'h3C, 20'h5A5A5, {$urandom, $urandom, $urandom, $urandom}, 2, 0, 0, 2'b00, EXP_AWID, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk_all_zero("poke_idle");
      @(posedge clk); #1;
    end

    // 6: async reset while beat 2 is on the bus
    begin
      int n;
      logic [127:0] l6;
      l6 = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
      wb_awready = 1; wb_wready = 0;
      info_miss = 1; info_rplc_dirty = 1; info_rplc_way = 0; core_index = 8'h44; info_rsp = 1;
      @(posedge clk); #1;
      info_rsp = 0; info_miss = 0; info_rplc_dirty = 0;
      @(posedge clk); #1;
      data_rdata0 = l6; tag_rdata0 = 20'h13579;
      n = 0;
      while (!(wb_wvalid && wb_wdata == 32'hCCCC0002) && n < 20) begin
        wb_wready = wb_wvalid;
        @(posedge clk); #1;
        n++;
      end
      chk("rst_reached_beat2", wb_wdata, 32'hCCCC0002);
      #2 reset = 0;
      #1 chk_all_zero("async_rst");
      chk("async_rst_awaddr", wb_awaddr, 0);
      wb_awready = 0; wb_wready = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_all_zero("rst_hold");
      reset = 1;
      @(posedge clk); #1;
      chk_all_zero("rst_release");
    end
    run_wb(1, 8'h44, 20'h2468A, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 2'b00, EXP_AWID, 0, 0, 1);

    // randomized transactions
    for (int t = 0; t < 12; t++) begin
      bit          rway, eb, minlat;
      int          awd, wm, bd;
      logic [1:0]  rresp;
      logic [3:0]  rid;
      rway  = 1'($urandom_range(0, 1));
      awd   = $urandom_range(0, 3);
      wm    = $urandom_range(0, 2);
      bd    = $urandom_range(0, 2);
      eb    = ($urandom_range(0, 3) == 0);
      rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rid   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : EXP_AWID;
      minlat = (awd == 0) && (wm == 0) && (bd == 0);
      run_wb(rway, 8'($urandom), 20'($urandom), {$urandom, $urandom, $urandom, $urandom},
             awd, wm, bd, rresp, rid, eb, 0, minlat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
